axis_packet_router: RTL and testbench
=====================================

AXIS_PACKET_ROUTER -- requirements
Module: axis_packet_router

Interface
REQ-001 SHALL provide parameters (one per line: name, default, meaning):
  DATA_W  64  stream data width in bits, minimum 8
  NUM_PORTS  4  number of output ports, 1..8
  CNT_W  16  width of the dropped-packet counter
REQ-002 SHALL provide ports (one per line: name  direction  width  meaning):
  i_clk  in  1  single clock; all logic rising-edge
  i_rst_n  in  1  reset, asynchronous, active-low
  i_s_axis_tdata  in  DATA_W  input beat; type field is tdata[7:0] of the first beat
  i_s_axis_tvalid  in  1  input beat valid
  i_s_axis_tlast  in  1  last beat of packet
  o_s_axis_tready  out  1  input ready
  o_m_axis_tdata  out  NUM_PORTS*DATA_W  port p occupies bits [p*DATA_W +: DATA_W]
  o_m_axis_tvalid  out  NUM_PORTS  per-port valid
  o_m_axis_tlast  out  NUM_PORTS  per-port last
  i_m_axis_tready  in  NUM_PORTS  per-port ready
  o_drop_count  out  CNT_W  dropped packets, saturating
  o_busy  out  1  high while mid-packet (state FWD or DROP)

Function
REQ-003 Input beat SHALL be accepted when i_s_axis_tvalid && o_s_axis_tready.
REQ-004 Type value t in 1..NUM_PORTS SHALL route to port t-1; any other value (including 0x00) SHALL mark the packet for drop.
REQ-005 The route SHALL be decided only on the first beat of a packet and held for every beat through the beat carrying tlast; type bytes of later beats SHALL be ignored.
REQ-006 The FSM SHALL have the states IDLE, FWD and DROP.
REQ-007 IDLE: an accepted routable beat without tlast -> FWD with the port latched; an accepted unroutable beat without tlast -> DROP; an accepted beat with tlast -> stay IDLE.
REQ-008 FWD or DROP: an accepted beat with tlast -> IDLE; otherwise stay.
REQ-009 Each port SHALL have a one-deep output register (data, valid, last); slot p is free when !o_m_axis_tvalid[p] || i_m_axis_tready[p].
REQ-010 o_s_axis_tready SHALL be combinational: in IDLE it is the target slot's free signal for a routable type and 1 for an unroutable type; in FWD it is the latched slot's free signal; in DROP it is 1.
REQ-011 An accepted routed beat SHALL appear on its port with tvalid high in the following cycle, data and tlast unmodified (latency 1).
REQ-012 A port register SHALL clear its valid on a cycle with valid && tready and no new load; a simultaneous drain and load SHALL give back-to-back valid beats (full throughput, no bubble).
REQ-013 At most one port SHALL be loaded per cycle, and a non-target port's register SHALL never change.
REQ-014 Dropped beats SHALL be consumed and never appear on any port.
REQ-015 o_drop_count SHALL increment by 1 on acceptance of the first beat of each unroutable packet and hold at 2^CNT_W-1.
REQ-016 While o_m_axis_tvalid[p] is high and i_m_axis_tready[p] is low, that port's data and tlast SHALL stay stable.

Reset
REQ-017 On i_rst_n low, all of the following SHALL clear asynchronously to 0: every o_m_axis_tvalid, o_m_axis_tdata and o_m_axis_tlast bit, o_drop_count and o_busy; the FSM SHALL go to IDLE.
REQ-018 Reset mid-packet SHALL abandon the packet; the first beat accepted after reset SHALL be treated as a new packet's first beat.
REQ-019 o_s_axis_tready SHALL be 0 while i_rst_n is low.

Verification
REQ-020 Single beat, type 0x02, tlast=1, all readies high -> port1 valid the next cycle with identical data, tlast=1; other ports idle; o_drop_count=0.
REQ-021 3-beat packet, first byte 0x01, later beats' byte0=0x03 -> all 3 beats on port0 in order, last on beat 3 only, port2 untouched.
REQ-022 Port2 ready held low, 2-beat packet to type 0x03 -> beat 1 held stable on port2, o_s_axis_tready=0, beat 2 stalled; raise ready -> both delivered, no loss or duplication.
REQ-023 Packet with type 0x00, then packet with type 0x07 (NUM_PORTS=4), each 2 beats -> tready=1 throughout, no port valid, o_drop_count=2; CNT_W=2 with 5 drops -> count=3.
REQ-024 Continuous 1-beat packets to port0, readies high -> one output beat per cycle, no bubbles.
REQ-025 Reset asserted after beat 1 of a 3-beat port1 packet -> outputs cleared; the next beat with byte0=0x04 routes to port3.

Source files
------------

// File: rtl/axis_packet_router_if.sv
// Stream bundle for axis_packet_router: one input stream plus NUM_PORTS
// output streams packed side by side (port p at [p*DATA_W +: DATA_W]).
interface axis_packet_router_if #(
  parameter int DATA_W    = 64,
  parameter int NUM_PORTS = 4
);
  logic [DATA_W-1:0]           i_s_axis_tdata;
  logic                        i_s_axis_tvalid;
  logic                        i_s_axis_tlast;
  logic                        o_s_axis_tready;
  logic [NUM_PORTS*DATA_W-1:0] o_m_axis_tdata;
  logic [NUM_PORTS-1:0]        o_m_axis_tvalid;
  logic [NUM_PORTS-1:0]        o_m_axis_tlast;
  logic [NUM_PORTS-1:0]        i_m_axis_tready;

  // Traffic source / sink side (drives the input stream, sinks the ports)
  modport master (
    output i_s_axis_tdata, i_s_axis_tvalid, i_s_axis_tlast, i_m_axis_tready,
    input  o_s_axis_tready, o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast
  );

  // Router side
  modport slave (
    input  i_s_axis_tdata, i_s_axis_tvalid, i_s_axis_tlast, i_m_axis_tready,
    output o_s_axis_tready, o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast
  );
endinterface

// File: rtl/axis_packet_router.sv
// Packet router: the low byte of a packet's first beat selects an output
// port (type t -> port t-1); unknown types are swallowed and counted.
// Each output port has a single register stage that supports full
// throughput (drain and reload in the same cycle).
module axis_packet_router #(
  parameter int DATA_W    = 64,
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  axis_packet_router_if.slave  bus,
  output logic [CNT_W-1:0]     o_drop_count,
  output logic                 o_busy
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                      state, next_state;
  logic [PORT_W-1:0]           port_q;
  logic [PORT_W-1:0]           target;
  logic [7:0]                  type_byte;
  logic                        routable;
  logic                        tready_int;
  logic                        accept;
  logic                        fwd;
  logic                        first_drop;
  logic                        latch_port;
  logic [NUM_PORTS-1:0]        slot_free;
  logic [NUM_PORTS-1:0]        load;
  logic [NUM_PORTS*DATA_W-1:0] data_q;
  logic [NUM_PORTS-1:0]        valid_q;
  logic [NUM_PORTS-1:0]        last_q;
  logic [CNT_W-1:0]            drop_q;

  assign type_byte = bus.i_s_axis_tdata[7:0];
  assign routable  = (type_byte != 8'd0) && (type_byte <= 8'(NUM_PORTS));
  assign slot_free = ~valid_q | bus.i_m_axis_tready;

  // Route decision, input ready and next state; route only sampled in IDLE
  always_comb begin
    next_state = state;
    target     = port_q;
    tready_int = 1'b0;
    accept     = 1'b0;
    fwd        = 1'b0;
    first_drop = 1'b0;
    latch_port = 1'b0;
    case (state)
      IDLE: begin
        if (routable) begin
          target     = PORT_W'(type_byte - 8'd1);
          tready_int = slot_free[target];
        end else begin
          tready_int = 1'b1;
        end
        accept = bus.i_s_axis_tvalid && tready_int;
        if (accept) begin
          fwd        = routable;
          first_drop = !routable;
          latch_port = routable;
          if (!bus.i_s_axis_tlast) begin
            next_state = routable ? FWD : DROP;
          end
        end
      end
      FWD: begin
        tready_int = slot_free[port_q];
        accept     = bus.i_s_axis_tvalid && tready_int;
        fwd        = accept;
        if (accept && bus.i_s_axis_tlast) begin
          next_state = IDLE;
        end
      end
      DROP: begin
        tready_int = 1'b1;
        accept     = bus.i_s_axis_tvalid;
        if (accept && bus.i_s_axis_tlast) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // One-hot load strobe for the single port receiving this cycle's beat
  always_comb begin
    load = '0;
    if (fwd) begin
      load[target] = 1'b1;
    end
  end

  // FSM state, latched route and saturating drop counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      port_q <= '0;
      drop_q <= '0;
    end else begin
      state <= next_state;
      if (latch_port) begin
        port_q <= target;
      end
      if (first_drop && (drop_q != {CNT_W{1'b1}})) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  // Per-port output registers: load wins over drain, untouched otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (load[p]) begin
          data_q[p*DATA_W +: DATA_W] <= bus.i_s_axis_tdata;
          last_q[p]                  <= bus.i_s_axis_tlast;
          valid_q[p]                 <= 1'b1;
        end else if (bus.i_m_axis_tready[p]) begin
          valid_q[p] <= 1'b0;
        end
      end
    end
  end

  assign bus.o_s_axis_tready = tready_int && i_rst_n;
  assign bus.o_m_axis_tdata  = data_q;
  assign bus.o_m_axis_tvalid = valid_q;
  assign bus.o_m_axis_tlast  = last_q;
  assign o_drop_count        = drop_q;
  assign o_busy              = (state != IDLE);

endmodule

// File: tb/tb_axis_packet_router.sv
// Testbench for axis_packet_router: directed scenarios plus random traffic.
// Accepted beats are pushed into per-port expected queues by a packet-level
// model; a monitor pops and compares whenever a port transfers a beat.
module tb_axis_packet_router;
  localparam int DATA_W    = 64;
  localparam int NUM_PORTS = 4;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_packet_router_if #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS)) bus ();
  axis_packet_router_if #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS)) bus2 ();

  logic [CNT_W-1:0] drop_count;
  logic             busy;
  logic [1:0]       drop_count2;
  logic             busy2;

  axis_packet_router #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus.slave),
    .o_drop_count(drop_count),
    .o_busy      (busy)
  );

  // Narrow-counter copy fed the same traffic, used for saturation
  axis_packet_router #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .CNT_W(2)) dut_sat (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus2.slave),
    .o_drop_count(drop_count2),
    .o_busy      (busy2)
  );

  assign bus2.i_s_axis_tdata  = bus.i_s_axis_tdata;
  assign bus2.i_s_axis_tvalid = bus.i_s_axis_tvalid;
  assign bus2.i_s_axis_tlast  = bus.i_s_axis_tlast;
  assign bus2.i_m_axis_tready = bus.i_m_axis_tready;

  int    checks   = 0;
  int    fails    = 0;
  int    rdy_mode = 0;
  beat_t sb_q [NUM_PORTS][$];

  bit first_beat = 1'b1;
  bit mid_pkt    = 1'b0;
  int cur_port   = -1;
  int exp_drops  = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet-level reference: route chosen by first beat's type byte
  task automatic model_accept(input logic [DATA_W-1:0] data, input logic last);
    int t;
    if (first_beat) begin
      t = int'(data[7:0]);
      if (t >= 1 && t <= NUM_PORTS) cur_port = t - 1;
      else begin
        cur_port = -1;
        exp_drops++;
      end
    end
    if (cur_port >= 0) sb_q[cur_port].push_back({data, last});
    first_beat = last;
    mid_pkt    = !last;
  endtask

  task automatic model_reset();
    for (int p = 0; p < NUM_PORTS; p++) sb_q[p].delete();
    first_beat = 1'b1;
    mid_pkt    = 1'b0;
    cur_port   = -1;
    exp_drops  = 0;
  endtask

  // Offer one beat; called and returns at posedge+1
  task automatic apply_stimulus(input logic [DATA_W-1:0] data, input logic last, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    bus.i_s_axis_tdata  = data;
    bus.i_s_axis_tlast  = last;
    bus.i_s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.o_s_axis_tready) begin
        model_accept(data, last);
        done = 1'b1;
      end else begin
        waits++;
        if (waits >= 200) begin
          checks++;
          fails++;
          $display("[TB] FAIL accept_timeout: got no tready expected tready within 200 cycles");
          done = 1'b1;
          waits = -1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.i_s_axis_tvalid = 1'b0;
    if (waits >= 0) check_output("busy", 64'(busy), 64'(mid_pkt));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (n < 200 && (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) != 0) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int p = 0; p < NUM_PORTS; p++)
      check_output($sformatf("drained_p%0d", p), 64'(sb_q[p].size()), 64'd0);
  endtask

  // Output ready generator: all high or random per cycle; mode 2 is manual
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.i_m_axis_tready = '1;
    else if (rdy_mode == 1) bus.i_m_axis_tready = NUM_PORTS'($urandom_range(0, 15));
  end

  // Monitor: compare transferred beats with the scoreboard, check stalls hold
  logic [DATA_W-1:0] held_data [NUM_PORTS];
  logic              held_last [NUM_PORTS];
  bit                stalled   [NUM_PORTS];
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) stalled[p] = 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        logic [DATA_W-1:0] d;
        logic              v, l, r;
        beat_t             e;
        d = bus.o_m_axis_tdata[p*DATA_W +: DATA_W];
        v = bus.o_m_axis_tvalid[p];
        l = bus.o_m_axis_tlast[p];
        r = bus.i_m_axis_tready[p];
        if (stalled[p]) begin
          check_output($sformatf("hold_valid_p%0d", p), 64'(v), 64'd1);
          check_output($sformatf("hold_data_p%0d", p), 64'(d), 64'(held_data[p]));
          check_output($sformatf("hold_last_p%0d", p), 64'(l), 64'(held_last[p]));
        end
        if (v && r) begin
          if (sb_q[p].size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_beat_p%0d: got data %0h expected no beat", p, d);
          end else begin
            e = sb_q[p].pop_front();
            check_output($sformatf("data_p%0d", p), 64'(d), 64'(e.data));
            check_output($sformatf("last_p%0d", p), 64'(l), 64'(e.last));
          end
        end
        stalled[p]   = v && !r;
        held_data[p] = d;
        held_last[p] = l;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rand_data(input logic [7:0] t);
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom};
    d[7:0] = t;
    return d;
  endfunction

  task automatic check_reset_state();
    check_output("rst_tvalid", 64'(bus.o_m_axis_tvalid), 64'd0);
    check_output("rst_tdata_or", 64'(|bus.o_m_axis_tdata), 64'd0);
    check_output("rst_tlast", 64'(bus.o_m_axis_tlast), 64'd0);
    check_output("rst_tready", 64'(bus.o_s_axis_tready), 64'd0);
    check_output("rst_drop", 64'(drop_count), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int w;
    logic [DATA_W-1:0] b1, b2;
    bus.i_s_axis_tvalid = 1'b0;
    bus.i_s_axis_tdata  = '0;
    bus.i_s_axis_tlast  = 1'b0;
    bus.i_m_axis_tready = '1;

    // Reset state
    #2;
    check_reset_state();
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat to port1
    b1 = rand_data(8'h02);
    apply_stimulus(b1, 1'b1, w);
    check_output("single_valid", 64'(bus.o_m_axis_tvalid), 64'b0010);
    check_output("single_data", 64'(bus.o_m_axis_tdata[DATA_W +: DATA_W]), 64'(b1));
    check_output("single_drop", 64'(drop_count), 64'd0);

    // Three-beat packet to port0; later type bytes ignored
    apply_stimulus(rand_data(8'h01), 1'b0, w);
    apply_stimulus(rand_data(8'h03), 1'b0, w);
    apply_stimulus(rand_data(8'h03), 1'b1, w);
    wait_drain();

    // Backpressure on port2
    rdy_mode = 2;
    bus.i_m_axis_tready = 4'b1011;
    b1 = rand_data(8'h03);
    b2 = rand_data(8'h03);
    apply_stimulus(b1, 1'b0, w);
    bus.i_s_axis_tdata  = b2;
    bus.i_s_axis_tlast  = 1'b1;
    bus.i_s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("stall_tready", 64'(bus.o_s_axis_tready), 64'd0);
      check_output("stall_data", 64'(bus.o_m_axis_tdata[2*DATA_W +: DATA_W]), 64'(b1));
    end
    @(posedge clk);
    #1;
    bus.i_m_axis_tready = '1;
    rdy_mode = 0;
    apply_stimulus(b2, 1'b1, w);
    wait_drain();

    // Dropped packets: type 0x00 and 0x07
    apply_stimulus(rand_data(8'h00), 1'b0, w);
    check_output("drop_wait", 64'(w), 64'd0);
    apply_stimulus(rand_data(8'h01), 1'b1, w);
    check_output("drop_wait", 64'(w), 64'd0);
    check_output("drop_novalid", 64'(bus.o_m_axis_tvalid), 64'd0);
    apply_stimulus(rand_data(8'h07), 1'b0, w);
    apply_stimulus(rand_data(8'h02), 1'b1, w);
    check_output("drop_novalid", 64'(bus.o_m_axis_tvalid), 64'd0);
    check_output("drop_count2", 64'(drop_count), 64'(exp_drops));
    repeat (3) apply_stimulus(rand_data(8'h05), 1'b1, w);
    check_output("drop_count5", 64'(drop_count), 64'(exp_drops));
    check_output("drop_sat", 64'(drop_count2), 64'd3);

    // Back-to-back single-beat packets to port0
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(rand_data(8'h01), 1'b1, w);
      check_output("b2b_wait", 64'(w), 64'd0);
      check_output("b2b_valid", 64'(bus.o_m_axis_tvalid[0]), 64'd1);
    end
    wait_drain();

    // Reset in the middle of a port1 packet
    apply_stimulus(rand_data(8'h02), 1'b0, w);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_state();
    check_output("rst_drop_sat", 64'(drop_count2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(rand_data(8'h04), 1'b1, w);
    check_output("post_rst_valid", 64'(bus.o_m_axis_tvalid), 64'b1000);
    wait_drain();

    // Random traffic with random output backpressure
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      int len;
      logic [7:0] t;
      len = $urandom_range(1, 4);
      t   = 8'($urandom_range(0, 6));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        apply_stimulus(rand_data((b == 0) ? t : 8'($urandom_range(0, 255))), 1'(b == len - 1), w);
      end
    end
    rdy_mode = 0;
    wait_drain();
    check_output("final_drop", 64'(drop_count), 64'((exp_drops > 65535) ? 65535 : exp_drops));
    check_output("final_drop_sat", 64'(drop_count2), 64'((exp_drops > 3) ? 3 : exp_drops));
    check_output("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
